display_scanner: RTL and testbench

Time-multiplexed driver for the board's bank of seven-segment digits. It double-buffers a hex word loaded from the datapath, such as PC, a register value or ALU output. It scans the word one nibble per digit period and drives the digit-enable lines. It sits directly upstream of the existing 4-bit-to-7-segment decoder: `oNibble` feeds the decoder's input, and `oBlank` forces the decoder output off at top level.

---
 rtl/display_scanner_pkg.sv | 18 +
 rtl/display_scanner_tick_gen.sv | 29 ++
 rtl/display_scanner.sv | 107 ++++++++++
 tb/tb_display_scanner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: default geometry, the
// per-digit phase encoding and the all-digits-off enable pattern.
package display_scanner_pkg;

  localparam int DEF_DIGITS   = 8;
  localparam int DEF_PRESCALE = 50000;
  localparam int DEF_DEAD     = 2;

  // Widest digit bank supported; the top slices its own width from this.
  localparam int MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] ALL_OFF_MAX = '1;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_t;

endpackage

// File: rtl/display_scanner_tick_gen.sv
// Prescaler for the digit scanner: counts 0..PRESCALE-1 and flags the last
// cycle of each digit period.
module tick_gen #(
  parameter  int PRESCALE = 50000,
  localparam int CW       = $clog2(PRESCALE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [CW-1:0] o_cnt,
  output logic          o_tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_tick = w_tick;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner: double-buffers a hex word and walks
// it one nibble per digit period, with a dead band and leading-zero blanking.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter  int DIGITS   = DEF_DIGITS,
  parameter  int PRESCALE = DEF_PRESCALE,
  parameter  int DEAD     = DEF_DEAD,
  localparam int W        = 4 * DIGITS
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [W-1:0]      iData,
  input  logic              iLoad,
  input  logic              iBlankLZ,
  output logic [3:0]        oNibble,
  output logic              oBlank,
  output logic [DIGITS-1:0] oDigitSel,
  output logic              oPending,
  output logic              oFrameDone,
  output phase_t            oPhase
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0]     DEAD_LAST = CW'((DEAD > 0) ? DEAD - 1 : 0);
  localparam phase_t            PH_START  = (DEAD > 0) ? PH_DEAD : PH_ON;
  localparam logic [DIGITS-1:0] ALL_OFF   = ALL_OFF_MAX[DIGITS-1:0];

  logic [CW-1:0] w_cnt;
  logic          w_tick;
  logic          w_boundary;
  logic          w_upper_zero;
  phase_t        r_phase, w_phase_nxt;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_disp, r_pend_data;
  logic          r_pending, r_frame_done;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .i_clk  (iCLK),
    .i_rst_n(iRST_n),
    .o_cnt  (w_cnt),
    .o_tick (w_tick)
  );

  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_phase <= PH_START;
    else         r_phase <= w_phase_nxt;
  end

  // Phase mirrors cnt < DEAD; it re-enters DEAD at every tick when DEAD > 0.
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_tick)                                        w_phase_nxt = PH_START;
    else if (r_phase == PH_DEAD && w_cnt == DEAD_LAST) w_phase_nxt = PH_ON;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // iLoad is a one-cycle strobe with no back-pressure: it is always accepted.
  // A load on the boundary tick bypasses the pending buffer and drops any
  // older pending word.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_disp      <= '0;
      r_pend_data <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (iLoad) r_pend_data <= iData;
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (iLoad)          r_disp <= iData;
        else if (r_pending) r_disp <= r_pend_data;
      end else if (iLoad) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= r_idx && r_disp[4*i +: 4] != 4'h0) w_upper_zero = 1'b0;
    end
  end

  assign oNibble    = r_disp[4*r_idx +: 4];
  assign oBlank     = (r_phase == PH_DEAD) ||
                      (iBlankLZ && r_idx != '0 && w_upper_zero);
  assign oDigitSel  = (r_phase == PH_DEAD) ? ALL_OFF
                                           : ~(DIGITS'(1) << r_idx);
  assign oPending   = r_pending;
  assign oFrameDone = r_frame_done;
  assign oPhase     = r_phase;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner against a cycle-count based reference
// model, with directed scenarios for loads, boundary loads, blanking and reset.
module tb_display_scanner;
  import display_scanner_pkg::*;

  localparam int DIGITS   = 8;
  localparam int PRESCALE = 4;
  localparam int DEAD     = 1;
  localparam int W        = 4 * DIGITS;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic              iCLK;
  logic              iRST_n;
  logic [W-1:0]      iData;
  logic              iLoad;
  logic              iBlankLZ;
  logic [3:0]        oNibble;
  logic              oBlank;
  logic [DIGITS-1:0] oDigitSel;
  logic              oPending;
  logic              oFrameDone;
  phase_t            oPhase;

  display_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iData     (iData),
    .iLoad     (iLoad),
    .iBlankLZ  (iBlankLZ),
    .oNibble   (oNibble),
    .oBlank    (oBlank),
    .oDigitSel (oDigitSel),
    .oPending  (oPending),
    .oFrameDone(oFrameDone),
    .oPhase    (oPhase)
  );

  // ---------------- clock / reset ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // t = active edges since reset release; scan position follows from it.
  int             t;
  logic [W-1:0]   m_disp;
  logic [W-1:0]   exp_q[$];   // loads waiting for the next frame boundary
  logic           m_fd;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_disp = '0;
    exp_q.delete();
    m_fd   = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [W-1:0] d);
    logic boundary;
    boundary = (t % FRAME) == FRAME - 1;
    if (boundary) begin
      if (ld) m_disp = d;
      else if (exp_q.size() != 0) m_disp = exp_q[$];
      exp_q.delete();
    end else if (ld) begin
      exp_q.push_back(d);
    end
    m_fd = boundary;
    t++;
  endtask

  task automatic check_all();
    int          cnt, idx;
    logic        dead, lz;
    logic [W-1:0] upper;
    logic [DIGITS-1:0] sel;
    cnt   = t % PRESCALE;
    idx   = (t / PRESCALE) % DIGITS;
    dead  = cnt < DEAD;
    upper = m_disp >> (4 * idx);
    lz    = iBlankLZ && idx > 0 && upper == '0;
    sel   = dead ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx);
    check("digit_sel", 32'(oDigitSel), 32'(sel));
    check("blank",     32'(oBlank),    32'(dead || lz));
    check("nibble",    32'(oNibble),   32'(upper[3:0]));
    check("pending",   32'(oPending),  32'(exp_q.size() != 0));
    check("frame_done",32'(oFrameDone),32'(m_fd));
    check("phase",     32'(oPhase),    32'(dead ? PH_DEAD : PH_ON));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic ld, input logic [W-1:0] d);
    iLoad = ld;
    iData = d;
    @(posedge iCLK);
    model_edge(ld, d);
    #1;
    iLoad = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic goto_idx(input int target);
    for (int i = 0; i < FRAME && ((t / PRESCALE) % DIGITS) != target; i++) step(1'b0, '0);
  endtask

  task automatic goto_boundary();
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #1;
    iRST_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge iCLK);
    iRST_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         ld;
    logic [W-1:0] d;
    logic [W-1:0] mask;
    n_vec    = 0;
    n_err    = 0;
    iRST_n   = 1'b0;
    iLoad    = 1'b0;
    iData    = '0;
    iBlankLZ = 1'b0;
    model_reset();
    #13;
    check_all();
    @(negedge iCLK);
    iRST_n = 1'b1;

    // Reset release and a couple of idle frames.
    idle(2 * FRAME + 3);

    // Mid-frame load at digit 3, committed at the next boundary.
    goto_idx(3);
    step(1'b1, 32'h1234ABCD);
    goto_boundary();
    idle(FRAME + 2);

    // Two loads in one frame: the last one wins.
    goto_idx(1);
    step(1'b1, 32'h11111111);
    idle(5);
    step(1'b1, 32'h22222222);
    goto_boundary();
    idle(FRAME + 2);

    // Load exactly on the boundary tick goes straight to the display.
    goto_boundary();
    step(1'b1, 32'h0000BEEF);
    idle(FRAME);

    // Leading-zero blanking.
    iBlankLZ = 1'b1;
    goto_idx(2);
    step(1'b1, 32'h000000A0);
    idle(2 * FRAME);
    step(1'b1, 32'h00000000);
    idle(2 * FRAME);
    iBlankLZ = 1'b0;

    // Reset in the middle of a frame with a load pending.
    goto_idx(2);
    step(1'b1, 32'hCAFE5678);
    goto_idx(5);
    do_reset();
    idle(FRAME + 4);

    // Randomized traffic, biased towards zero-topped words and boundary loads.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 31) == 0) iBlankLZ = ~iBlankLZ;
      ld   = ($urandom_range(0, 15) == 0);
      if ((t % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0) ld = 1'b1;
      mask = 32'hFFFFFFFF >> (4 * $urandom_range(0, 8));
      d    = $urandom & mask;
      step(ld, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
